// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared operator codes, FSM states and constants for calc_alu
package calc_pkg;

  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_MUL = 3'd3;
  localparam logic [2:0] OP_DIV = 3'd4;
  localparam logic [2:0] OP_MOD = 3'd5;

  localparam logic [15:0] DIV0_RESULT = 16'hFFFF;
  localparam int          ITER_CNT    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Operators that walk one operand bit per cycle.
  function automatic logic is_iterative(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
  endfunction

  // Divide and modulo share the divider and the divide-by-zero shortcut.
  function automatic logic is_divide(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/calc_divider.sv
// rtl/calc_divider.sv - one step of an 8-bit restoring divider
module calc_divider (
  input  logic       i_en,
  input  logic [7:0] i_rem,
  input  logic [7:0] i_divisor,
  input  logic [7:0] i_quo,
  output logic [7:0] o_rem,
  output logic [7:0] o_quo
);

  // Partial remainder shifted left with the next dividend bit brought in.
  // The dividend lives in the quotient register and drains out of its MSB
  // while quotient bits fill in from the LSB.
  logic [8:0] w_shift;
  assign w_shift = {i_rem, i_quo[7]};

  // Trial subtract; keep the difference only when it does not go negative.
  // The kept remainder is always below the divisor, so 8 bits suffice.
  always_comb begin
    o_rem = i_rem;
    o_quo = i_quo;
    if (i_en) begin
      if (w_shift >= {1'b0, i_divisor}) begin
        o_rem = w_shift[7:0] - i_divisor;
        o_quo = {i_quo[6:0], 1'b1};
      end else begin
        o_rem = w_shift[7:0];
        o_quo = {i_quo[6:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/calc_alu.sv
// rtl/calc_alu.sv - sequential 8-bit ALU: add/sub in one cycle, mul/div/mod in eight
module calc_alu
  import calc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  data_a,
  input  logic [7:0]  data_b,
  input  logic [2:0]  sign,
  output logic        busy,
  output logic        done,
  output logic [15:0] ans_num,
  output logic        err
);

  state_t      r_state;
  state_t      w_next_state;

  logic [7:0]  r_a;
  logic [7:0]  r_b;
  logic [2:0]  r_op;
  logic [2:0]  r_cnt;

  logic [15:0] r_acc;
  logic [15:0] r_mcand;
  logic [7:0]  r_mplier;

  logic [7:0]  r_rem;
  logic [7:0]  r_quo;

  logic [15:0] r_ans;
  logic        r_err;

  logic        w_div0;
  logic        w_fast;
  logic        w_last;
  logic        w_write;
  logic [15:0] w_mul_next;
  logic [7:0]  w_rem_next;
  logic [7:0]  w_quo_next;
  logic [15:0] w_fast_ans;
  logic        w_fast_err;
  logic [15:0] w_iter_ans;

  // Single-cycle ops finish on the first CALC edge; iterative ops finish
  // when the 3-bit counter is about to wrap from 7 back to 0.
  assign w_div0  = is_divide(r_op) && (r_b == 8'd0);
  assign w_fast  = !is_iterative(r_op) || w_div0;
  assign w_last  = (r_cnt == 3'(ITER_CNT - 1));
  assign w_write = (r_state == CALC) && (w_fast || w_last);

  // Shift-add: the multiplicand moves left while the multiplier's LSB
  // decides whether it is accumulated this cycle.
  assign w_mul_next = r_acc + (r_mplier[0] ? r_mcand : 16'h0000);

  calc_divider u_divider (
    .i_en      (r_state == CALC),
    .i_rem     (r_rem),
    .i_divisor (r_b),
    .i_quo     (r_quo),
    .o_rem     (w_rem_next),
    .o_quo     (w_quo_next)
  );

  // Result of the single-cycle paths, including both error cases.
  always_comb begin
    w_fast_ans = 16'h0000;
    w_fast_err = 1'b1;
    case (r_op)
      OP_ADD: begin
        w_fast_ans = {8'h00, r_a} + {8'h00, r_b};
        w_fast_err = 1'b0;
      end
      OP_SUB: begin
        w_fast_ans = {8'h00, r_a} - {8'h00, r_b};
        w_fast_err = 1'b0;
      end
      OP_DIV, OP_MOD: begin
        w_fast_ans = DIV0_RESULT;
        w_fast_err = 1'b1;
      end
      default: begin
        w_fast_ans = 16'h0000;
        w_fast_err = 1'b1;
      end
    endcase
  end

  // Result of the iterative paths, taken from this cycle's step outputs so
  // the final iteration and the result write happen on the same edge.
  always_comb begin
    w_iter_ans = 16'h0000;
    case (r_op)
      OP_MUL:  w_iter_ans = w_mul_next;
      OP_DIV:  w_iter_ans = {8'h00, w_quo_next};
      default: w_iter_ans = {8'h00, w_rem_next};
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and status outputs; start is only looked at in IDLE.
  always_comb begin
    w_next_state = r_state;
    busy         = 1'b1;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_next_state = CALC;
        end
      end
      CALC: begin
        if (w_write) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        done         = 1'b1;
        w_next_state = IDLE;
      end
      default: begin
        busy         = 1'b0;
        w_next_state = IDLE;
      end
    endcase
  end

  // Operand latch, iteration datapath and the result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= 8'h00;
      r_b      <= 8'h00;
      r_op     <= 3'd0;
      r_cnt    <= 3'd0;
      r_acc    <= 16'h0000;
      r_mcand  <= 16'h0000;
      r_mplier <= 8'h00;
      r_rem    <= 8'h00;
      r_quo    <= 8'h00;
      r_ans    <= 16'h0000;
      r_err    <= 1'b0;
    end else begin
      if ((r_state == IDLE) && start) begin
        r_a      <= data_a;
        r_b      <= data_b;
        r_op     <= sign;
        r_cnt    <= 3'd0;
        r_acc    <= 16'h0000;
        r_mcand  <= {8'h00, data_a};
        r_mplier <= data_b;
        r_rem    <= 8'h00;
        r_quo    <= data_a;
      end else if (r_state == CALC) begin
        r_cnt    <= r_cnt + 3'd1;
        r_acc    <= w_mul_next;
        r_mcand  <= {r_mcand[14:0], 1'b0};
        r_mplier <= {1'b0, r_mplier[7:1]};
        r_rem    <= w_rem_next;
        r_quo    <= w_quo_next;
        if (w_write) begin
          r_cnt <= 3'd0;
          r_ans <= w_fast ? w_fast_ans : w_iter_ans;
          r_err <= w_fast ? w_fast_err : 1'b0;
        end
      end
    end
  end

  assign ans_num = r_ans;
  assign err     = r_err;

endmodule

// File: tb/tb_calc_alu.sv
// tb/tb_calc_alu.sv - self-checking bench for calc_alu
module tb_calc_alu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  data_a = 8'h00;
  logic [7:0]  data_b = 8'h00;
  logic [2:0]  sign = 3'd0;
  logic        busy;
  logic        done;
  logic [15:0] ans_num;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int e0 = 0;

  calc_alu dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .data_a  (data_a),
    .data_b  (data_b),
    .sign    (sign),
    .busy    (busy),
    .done    (done),
    .ans_num (ans_num),
    .err     (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [2:0]  op;
    logic [15:0] ans;
    logic        err;
    int          lat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: results straight from the operator definitions.
  task automatic ref_model(input int a, input int b, input int op,
                           output logic [15:0] ans, output logic e, output int lat);
    ans = 16'h0000; e = 1'b1; lat = 1;
    case (op)
      1: begin ans = 16'(a + b); e = 1'b0; end
      2: begin ans = 16'((a - b + 65536) % 65536); e = 1'b0; end
      3: begin ans = 16'(a * b); e = 1'b0; lat = 8; end
      4, 5: begin
        if (b == 0) begin
          ans = 16'hFFFF;
        end else begin
          ans = (op == 4) ? 16'(a / b) : 16'(a % b);
          e = 1'b0; lat = 8;
        end
      end
      default: begin ans = 16'h0000; e = 1'b1; end
    endcase
  endtask

  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    @(negedge clk);
    data_a = a; data_b = b; sign = op; start = 1'b1;
    @(posedge clk);
    #1;
    e0 = cyc;
    start = 1'b0;
    data_a = 8'($urandom); data_b = 8'($urandom); sign = 3'($urandom);
    chk("busy_after_e0", busy, 1'b1);
  endtask

  task automatic wait_done(output logic [15:0] ans, output logic e, output int lat);
    logic [15:0] prev;
    logic got;
    prev = ans_num;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        got = 1'b1;
        break;
      end
      chk("ans_held", ans_num, prev);
      chk("busy_in_calc", busy, 1'b1);
    end
    chk("done_seen", got, 1'b1);
    chk("busy_in_done", busy, 1'b1);
    ans = ans_num;
    e = err;
    lat = cyc - e0;
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        input logic [15:0] x_ans, input logic x_err, input int x_lat);
    logic [15:0] g_ans;
    logic g_err;
    int g_lat;
    start_op(a, b, op);
    wait_done(g_ans, g_err, g_lat);
    chk("ans", g_ans, x_ans);
    chk("err", g_err, x_err);
    chk("latency", g_lat, x_lat);
    @(posedge clk);
    #1;
    chk("done_single", done, 1'b0);
    chk("busy_idle", busy, 1'b0);
    chk("ans_stable", ans_num, x_ans);
  endtask

  vec_t vecs[$];

  initial begin
    logic [15:0] r_ans;
    logic r_err;
    int r_lat;
    logic [15:0] g_ans;
    logic g_err;
    int g_lat;

    vecs = '{
      '{8'd255, 8'd255, 3'd1, 16'h01FE, 1'b0, 1},
      '{8'd1,   8'd2,   3'd2, 16'hFFFF, 1'b0, 1},
      '{8'd255, 8'd255, 3'd3, 16'hFE01, 1'b0, 8},
      '{8'd200, 8'd7,   3'd4, 16'h001C, 1'b0, 8},
      '{8'd200, 8'd7,   3'd5, 16'h0004, 1'b0, 8},
      '{8'd9,   8'd0,   3'd4, 16'hFFFF, 1'b1, 1},
      '{8'd0,   8'd0,   3'd1, 16'h0000, 1'b0, 1},
      '{8'd9,   8'd0,   3'd5, 16'hFFFF, 1'b1, 1},
      '{8'd9,   8'd3,   3'd7, 16'h0000, 1'b1, 1},
      '{8'd0,   8'd255, 3'd2, 16'hFF01, 1'b0, 1},
      '{8'd9,   8'd3,   3'd0, 16'h0000, 1'b1, 1},
      '{8'd0,   8'd255, 3'd3, 16'h0000, 1'b0, 8},
      '{8'd9,   8'd3,   3'd6, 16'h0000, 1'b1, 1},
      '{8'd255, 8'd1,   3'd4, 16'h00FF, 1'b0, 8},
      '{8'd7,   8'd200, 3'd5, 16'h0007, 1'b0, 8},
      '{8'd5,   8'd255, 3'd4, 16'h0000, 1'b0, 8},
      '{8'd128, 8'd2,   3'd3, 16'h0100, 1'b0, 8}
    };

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_ans", ans_num, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    // Directed table.
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].ans, vecs[i].err, vecs[i].lat);
    end

    // Randomized operations against the reference.
    for (int i = 0; i < 40; i++) begin
      logic [7:0] a;
      logic [7:0] b;
      logic [2:0] op;
      a = 8'($urandom);
      b = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
      op = 3'($urandom_range(0, 7));
      ref_model(int'(a), int'(b), int'(op), r_ans, r_err, r_lat);
      run_op(a, b, op, r_ans, r_err, r_lat);
    end

    // start pulsed at E3 of a multiply is ignored.
    start_op(8'd255, 8'd255, 3'd3);
    repeat (2) @(posedge clk);
    @(negedge clk);
    data_a = 8'd1; data_b = 8'd1; sign = 3'd1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(g_ans, g_err, g_lat);
    chk("ignored_start_ans", g_ans, 16'hFE01);
    chk("ignored_start_lat", g_lat, 8);
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("no_queued_op", busy, 1'b0);
    end

    // Reset at E4 of a multiply clears everything at once.
    start_op(8'd17, 8'd19, 3'd3);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_ans", ans_num, 16'h0000);
    chk("midrst_err", err, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    run_op(8'd10, 8'd20, 3'd1, 16'd30, 1'b0, 1);

    // start held high: a new op on every IDLE visit with fresh inputs.
    @(negedge clk);
    data_a = 8'd3; data_b = 8'd4; sign = 3'd1; start = 1'b1;
    @(posedge clk);
    #1;
    e0 = cyc;
    data_a = 8'd5; data_b = 8'd6; sign = 3'd2;
    wait_done(g_ans, g_err, g_lat);
    chk("held_first_ans", g_ans, 16'd7);
    @(posedge clk);
    #1;
    chk("held_idle_gap", busy, 1'b0);
    @(posedge clk);
    #1;
    e0 = cyc;
    start = 1'b0;
    chk("held_restart", busy, 1'b1);
    wait_done(g_ans, g_err, g_lat);
    chk("held_second_ans", g_ans, 16'hFFFF);
    chk("held_second_err", g_err, 1'b0);
    chk("held_second_lat", g_lat, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
